// File: rtl/shift_register.sv
// rtl/shift_register.sv - DEPTH x WIDTH enabled shift register; optional sim checks under SHIFT_REGISTER_ASSERT_EN
module shift_register #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shiftEnable,
  input  logic [WIDTH-1:0] wordIn,
  output logic [WIDTH-1:0] wordOut
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (shiftEnable) begin
      stage_d[0] = wordIn;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign wordOut = stage_q[DEPTH-1];

`ifdef SHIFT_REGISTER_ASSERT_EN
  if (DEPTH < 1 || WIDTH < 1) begin : g_bad_params
    $error("shift_register: DEPTH and WIDTH must both be >= 1");
  end

  // Shadow model: oldest word at the back, rebuilt with DEPTH zeros on reset.
  logic [WIDTH-1:0] model_q [$];
  logic             seen_reset_q;
  int unsigned      cycle_q;

  always @(posedge clk) begin
    cycle_q <= cycle_q + 1;
    if (seen_reset_q && !reset) begin
      if ($isunknown(shiftEnable) || $isunknown(reset))
        $error("shift_register: X/Z on control at cycle %0d", cycle_q);
      if (shiftEnable === 1'b1 && $isunknown(wordIn))
        $error("shift_register: X/Z on wordIn at cycle %0d", cycle_q);
      if (model_q.size() == DEPTH && wordOut !== model_q[DEPTH-1])
        $error("shift_register: wordOut %h != model %h at cycle %0d",
               wordOut, model_q[DEPTH-1], cycle_q);
    end
    if (reset === 1'b1) begin
      seen_reset_q <= 1'b1;
      model_q.delete();
      for (int i = 0; i < DEPTH; i++) model_q.push_back('0);
    end else if (shiftEnable === 1'b1 && model_q.size() == DEPTH) begin
      model_q.push_front(wordIn);
      void'(model_q.pop_back());
    end
  end
`endif

endmodule

// File: tb/tb_shift_register.sv
// tb/tb_shift_register.sv - table, directed and random checks of shift_register
module tb_shift_register;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0, en_a = 1'b0;
  logic [7:0]  din_a = '0;
  logic [7:0]  dout_a;
  logic        rst_b = 1'b0, en_b = 1'b0;
  logic [15:0] din_b = '0;
  logic [15:0] dout_b;

  int n_checks = 0;
  int n_fail = 0;

  shift_register #(.DEPTH(4), .WIDTH(8)) dut_a (
    .clk(clk), .reset(rst_a), .shiftEnable(en_a), .wordIn(din_a), .wordOut(dout_a)
  );

  shift_register #(.DEPTH(1), .WIDTH(16)) dut_b (
    .clk(clk), .reset(rst_b), .shiftEnable(en_b), .wordIn(din_b), .wordOut(dout_b)
  );

  always #5 clk = ~clk;

  // Reference: every word accepted since the last reset, in arrival order.
  logic [7:0] hist [$];

  function automatic logic [7:0] model_out();
    if (hist.size() >= 4) return hist[hist.size() - 4];
    return 8'h00;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic r, input logic e, input logic [7:0] d);
    rst_a = r; en_a = e; din_a = d;
    @(posedge clk);
    #1;
    if (r) hist.delete();
    else if (e) hist.push_back(d);
  endtask

  task automatic step_b(input logic r, input logic e, input logic [15:0] d);
    rst_b = r; en_b = e; din_b = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [14];
  logic [7:0] w;
  logic [7:0] snap;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 8'hFF, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 8'hFF, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 8'hFF, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 8'h11, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 8'h22, 8'h00};
    tbl[6]  = '{1'b0, 1'b1, 8'h33, 8'h00};
    tbl[7]  = '{1'b0, 1'b1, 8'h44, 8'h11};
    tbl[8]  = '{1'b0, 1'b0, 8'hAA, 8'h11};
    tbl[9]  = '{1'b0, 1'b0, 8'hBB, 8'h11};
    tbl[10] = '{1'b0, 1'b0, 8'hAA, 8'h11};
    tbl[11] = '{1'b0, 1'b1, 8'h55, 8'h22};
    tbl[12] = '{1'b0, 1'b1, 8'h66, 8'h33};
    tbl[13] = '{1'b0, 1'b1, 8'h77, 8'h44};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      step_a(tbl[i].rst, tbl[i].en, tbl[i].din);
      check($sformatf("tbl[%0d]", i), {8'h00, dout_a}, {8'h00, tbl[i].exp});
    end

    // Interleaved enable: only enabled edges count toward the latency.
    step_a(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) begin
      w = 8'($urandom);
      if (i % 2 == 0) w = 8'(i / 2 + 1);
      step_a(1'b0, (i % 2 == 0), w);
      check($sformatf("interleave[%0d]", i), {8'h00, dout_a}, (i == 6) ? 16'h0001 : 16'h0000);
    end

    // Mid-operation reset flushes in-flight words.
    step_a(1'b1, 1'b0, 8'h00);
    step_a(1'b0, 1'b1, 8'h11);
    step_a(1'b0, 1'b1, 8'h22);
    step_a(1'b0, 1'b1, 8'h33);
    step_a(1'b0, 1'b1, 8'h44);
    check("preflush", {8'h00, dout_a}, 16'h0011);
    step_a(1'b1, 1'b1, 8'h99);
    check("flush", {8'h00, dout_a}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step_a(1'b0, 1'b1, 8'(8'hC0 + i));
      check($sformatf("postflush[%0d]", i), {8'h00, dout_a}, (i == 3) ? 16'h00C0 : 16'h0000);
    end

    // Between edges neither reset nor wordIn may reach wordOut.
    snap = dout_a;
    #2;
    rst_a = 1'b1; din_a = ~din_a; en_a = 1'b1;
    #2;
    check("sync_reset", {8'h00, dout_a}, {8'h00, snap});
    step_a(1'b1, 1'b1, 8'h00);
    check("reset_edge", {8'h00, dout_a}, 16'h0000);

    // DEPTH=1, WIDTH=16.
    step_b(1'b1, 1'b1, 16'hFFFF);
    check("b_reset", dout_b, 16'h0000);
    step_b(1'b0, 1'b1, 16'hBEEF);
    check("b_load", dout_b, 16'hBEEF);
    step_b(1'b0, 1'b0, 16'h1234);
    check("b_hold0", dout_b, 16'hBEEF);
    step_b(1'b0, 1'b0, 16'h5678);
    check("b_hold1", dout_b, 16'hBEEF);
    step_b(1'b0, 1'b1, 16'h1234);
    check("b_load2", dout_b, 16'h1234);
    step_b(1'b1, 1'b1, 16'hAAAA);
    check("b_reset2", dout_b, 16'h0000);

    // Random traffic against the history model.
    for (int i = 0; i < 400; i++) begin
      step_a(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1, 8'($urandom));
      check($sformatf("rand[%0d]", i), {8'h00, dout_a}, {8'h00, model_out()});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_register.md
Name: shift_register

Overview:
- Parameterised synchronous word-wide shift register: a chain of DEPTH stages, each WIDTH bits wide.
- Advances one stage per clock only when shiftEnable is high.
- Used as a programmable-delay line / FIFO-less word pipeline between datapath blocks.
- Output is the last stage, fully registered (no combinational path from wordIn to wordOut).

Parameters:
- DEPTH, 4, number of stages; also the delay in enabled shifts; legal range >= 1.
- WIDTH, 8, bits per word; legal range >= 1.
- Positional order: DEPTH first, then WIDTH.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- shiftEnable  input  1  when high at a rising edge, the chain shifts by one stage.
- wordIn  input  WIDTH  word loaded into stage 0 on an enabled shift.
- wordOut  output  WIDTH  contents of stage DEPTH-1.
- Port order is as listed; the block is instantiated positionally.

Behaviour:
- State: stage[0..DEPTH-1], each WIDTH bits, all flops on clk rising edge.
- Reset: if reset=1 at a rising edge, all stages clear to 0, so wordOut=0 after that edge.
  - Reset has priority over shiftEnable.
  - Reset mid-operation discards all in-flight words.
  - Reset is synchronous: no effect between clock edges.
- Enabled shift (reset=0, shiftEnable=1):
  - stage[0] <= wordIn.
  - stage[i] <= stage[i-1] for 1 <= i <= DEPTH-1.
  - The old stage[DEPTH-1] is dropped.
- Hold (reset=0, shiftEnable=0): all stages keep their value; wordOut is stable.
- Latency: a word sampled on enabled shift N appears on wordOut immediately after enabled shift N+DEPTH-1.
  - That is, it needs DEPTH enabled edges including its own load.
  - Disabled cycles in between do not count and do not lose data.
- wordOut updates only on clk rising edges; it never changes combinationally with wordIn or shiftEnable.
- Before DEPTH enabled shifts after reset, wordOut shows 0 (the reset value propagating).
- DEPTH=1 case: wordOut is wordIn registered once when enabled.
- Arithmetic: none; words pass bit-exact, no width conversion.

Optional Feature:
- Macro: SHIFT_REGISTER_ASSERT_EN.
- Defined: simulation-only checks are compiled into the block.
  - After reset deasserts, flag an error if shiftEnable or reset is X/Z at a rising edge.
  - Flag an error if wordIn is X/Z when shiftEnable=1.
  - An internal reference model (same depth queue, pushed on enabled shifts) compares wordOut every cycle; mismatch reports $error with the cycle count.
  - Flag an elaboration-time error if DEPTH < 1 or WIDTH < 1.
- Undefined: none of this logic exists; the synthesised datapath is identical in both cases.

Test Plan (DEPTH=4, WIDTH=8, 10 ns clock):
- Reset: hold reset=1 for 2 edges with shiftEnable=1, wordIn=FF -> wordOut=00 throughout; first edge after release loads FF into stage 0 only, wordOut still 00.
- Fill and latency: after reset, shiftEnable=1 and wordIn=11,22,33,44,55 on consecutive edges -> wordOut=00,00,00,11,22 after each edge respectively.
- Hold: after wordOut=11, drop shiftEnable for 3 cycles while wordIn toggles AA/BB -> wordOut stays 11; on re-enable the next outputs are 22,33,44 in order, with no AA/BB inserted.
- Interleaved enable: enable pattern 1,0,1,0,1,0,1 with wordIn 01,xx,02,xx,03,xx,04 -> wordOut=01 only after the 4th enabled edge; disabled edges change nothing.
- Mid-operation reset: with stages holding 44,33,22,11, assert reset for one edge with shiftEnable=1 -> all stages 00, wordOut=00; the next 3 enabled shifts still output 00.
- Parameter sweep: DEPTH=1, WIDTH=16, wordIn=BEEF with enable -> wordOut=BEEF after exactly one edge; with enable low, wordOut holds.
